seg7_scan5: RTL

Five-digit multiplexed 7-segment display driver for the DAC board. It takes the 19-bit packed BCD word from the binary-to-BCD stage: digit 4 is 3 bits, digits 3..0 are 4 bits each. A new value is held in a pending register and copied into the display register only at a frame boundary, so a displayed frame never mixes two values. The block scans one anode at a time, blanks leading zeros and drives active-low segment and anode pins.

---
 rtl/seg7_scan5.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan5.sv
// Five-digit multiplexed 7-segment driver: scans one active-low anode at a time and
// swaps in a new BCD value only at the digit-0 to digit-4 frame boundary.
module seg7_scan5 #(
    parameter int DIV      = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [18:0] bcd_i,
    input  logic        bcd_valid_i,
    output logic        bcd_ready_o,
    output logic [4:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_done_o
);

    localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [18:0]   pend_q, pend_d;
    logic [18:0]   disp_q, disp_d;
    logic          pflag_q, pflag_d;
    logic          load_q, load_d;
    logic [4:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q;
    logic          frame_done_q;
    logic          tick_s, fb_s, blank_s;
    logic [3:0]    digit_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick_s = (pcnt_q == PMAX);
    assign fb_s   = tick_s && (idx_q == 3'd0);

    // Next-state logic for scan counters and the pending/display registers
    always_comb begin
        pcnt_d  = tick_s ? '0 : pcnt_q + PW'(1);
        idx_d   = idx_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        pflag_d = pflag_q;
        load_d  = 1'b0;
        if (idx_q > 3'd4) begin
            idx_d = 3'd4;
        end else if (tick_s) begin
            idx_d = (idx_q == 3'd0) ? 3'd4 : idx_q - 3'd1;
        end else begin
            idx_d = idx_q;
        end
        if (bcd_valid_i) begin
            pend_d  = bcd_i;
            pflag_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        // A strobe landing on the boundary goes straight to the display
        if (fb_s && bcd_valid_i) begin
            disp_d  = bcd_i;
            pflag_d = 1'b0;
            load_d  = 1'b1;
        end else if (fb_s && pflag_q) begin
            disp_d  = pend_q;
            pflag_d = 1'b0;
            load_d  = 1'b1;
        end else begin
            disp_d = disp_q;
        end
    end

    // Digit selection, leading-zero blanking and pin encoding from current registers
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        case (idx_q)
            3'd4: begin digit_s = {1'b0, disp_q[18:16]}; blank_s = (disp_q[18:16] == 3'd0);  end
            3'd3: begin digit_s = disp_q[15:12];         blank_s = (disp_q[18:12] == 7'd0);  end
            3'd2: begin digit_s = disp_q[11:8];          blank_s = (disp_q[18:8]  == 11'd0); end
            3'd1: begin digit_s = disp_q[7:4];           blank_s = (disp_q[18:4]  == 15'd0); end
            3'd0: begin digit_s = disp_q[3:0];           blank_s = 1'b0;                     end
            default: begin digit_s = 4'd0;               blank_s = 1'b1;                     end
        endcase
        an_d = 5'b11111 & ~(5'b00001 << idx_q);
        if (BLANK_LZ && blank_s) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = seg_decode(digit_s);
        end
    end

    // State and registered pin outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q       <= '0;
            idx_q        <= 3'd4;
            pend_q       <= 19'd0;
            disp_q       <= 19'd0;
            pflag_q      <= 1'b0;
            load_q       <= 1'b0;
            an_q         <= 5'b11111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pflag_q      <= pflag_d;
            load_q       <= load_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= 1'b1;
            frame_done_q <= load_q;
        end
    end

    assign bcd_ready_o  = ~pflag_q;
    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;

endmodule
